sb_tx_pkt_serializer: RTL and testbench
=======================================

Name: sb_tx_pkt_serializer

Overview:
Sideband transmit serializer. It takes one 64-bit sideband packet over a valid/ready handshake and shifts it out LSB first on a single data lane. It generates the enable for the sideband clock-gating cell, so the forwarded clock toggles only while packet bits are on the lane. It then enforces the mandatory idle gap: data low and clock gated, before the next packet. It sits between the sideband packet builder and the clock-gating cell / sideband pad driver.

Parameters:
PKT_W, 64, packet length in bits (UI)
GAP_W, 32, idle UI after each packet (data low, clock gated)
CNT_W, 7, counter width; must satisfy 2^CNT_W > max(PKT_W+1, GAP_W)

Ports:
CLK  in  1  sideband serial clock (ungated)
RST_N  in  1  asynchronous active-low reset
PKT_DATA  in  PKT_W  packet to send, bit 0 transmitted first
PKT_VALID  in  1  PKT_DATA valid
PKT_READY  out  1  serializer can accept a packet this cycle
CLK_EN  out  1  enable to clock-gating cell EN input, registered
SER_DATA  out  1  serial data to pad, registered
BUSY  out  1  high while not in IDLE
PKT_DONE  out  1  one-cycle pulse, packet plus gap complete

Behaviour:
- Reset (RST_N low, async): state=IDLE, counter=0, shift register=0, CLK_EN=0, SER_DATA=0, BUSY=0, PKT_DONE=0. PKT_READY=1 once RST_N is deasserted.
- Reset mid-packet: outputs drop to 0 immediately (gated clock stops). The packet is discarded and not resent.
- All outputs except PKT_READY are flops clocked on CLK rising. PKT_READY is combinational from state/counter.
- Handshake: a transfer occurs on a rising edge with PKT_VALID=1 and PKT_READY=1. PKT_DATA is captured into the shift register on that edge (edge A).
- PKT_READY=1 in IDLE, and in GAP when counter==GAP_W-1 (last gap cycle), allowing back-to-back packets. Otherwise 0. PKT_VALID while not ready is ignored and holds no state.
- States:
  - IDLE -> SHIFT on transfer.
  - SHIFT lasts PKT_W+1 cycles, counter 0..PKT_W.
  - SHIFT -> GAP when counter==PKT_W.
  - GAP lasts GAP_W cycles, counter 0..GAP_W-1.
  - GAP -> SHIFT on transfer in the last gap cycle; otherwise GAP -> IDLE.
- Clock-gating alignment: the gating cell latches EN in the CLK low phase, so a change on CLK_EN takes effect on the gated clock one cycle later. CLK_EN therefore leads SER_DATA by exactly one cycle.
- SHIFT timeline after edge A:
  - Cycle A+1 (counter 0): CLK_EN=1, SER_DATA=0.
  - Cycles A+1+k, k=1..PKT_W-1: CLK_EN=1, SER_DATA=PKT_DATA[k-1].
  - Cycle A+1+PKT_W: CLK_EN=0, SER_DATA=PKT_DATA[PKT_W-1].
  - Result: the gated clock shows exactly PKT_W pulses, pulse k coinciding with bit k on SER_DATA. The receiver samples on the gated-clock falling edge.
- GAP: SER_DATA=0, CLK_EN=0 for GAP_W cycles.
- Back-to-back: a new packet accepted in the last GAP cycle gets CLK_EN=1 in the very next cycle. There is no extra idle cycle.
- PKT_DONE=1 for exactly one cycle, the cycle after the last GAP cycle. This coincides with IDLE, or with counter 0 of the next SHIFT.
- BUSY=1 in SHIFT and GAP, 0 in IDLE (registered together with state).
- Counter never wraps: it is cleared on every state change. Out-of-range counter values are unreachable.

Test Plan:
- Reset check: RST_N=0 mid-stream, then release -> all outputs 0 immediately; PKT_READY=1 after release; no gated-clock pulses.
- Single packet PKT_DATA=64'hA5A5_0000_FFFF_1234, VALID pulsed for one cycle in IDLE:
  - CLK_EN high for exactly 64 cycles starting A+1.
  - SER_DATA bits read at cycles A+2..A+65 reconstruct 64'hA5A5_0000_FFFF_1234, LSB first.
  - SER_DATA=0 and CLK_EN=0 for 32 cycles after that.
  - PKT_DONE pulses at A+98 (after the 32 GAP cycles A+66..A+97).
- Gating-cell integration: instantiate with the clock-gating cell and count GATED_CLK rising edges -> exactly 64 per packet. Sampling SER_DATA on GATED_CLK falling edges recovers the packet. No runt pulses.
- Back-to-back: hold PKT_VALID=1 with two packets 64'h1 and 64'h8000_0000_0000_0000 -> second transfer at the last GAP cycle of the first. CLK_EN rises the next cycle. The idle gap between the packets is exactly 32 cycles. Two PKT_DONE pulses, 97 cycles apart.
- Stall: PKT_VALID asserted during SHIFT cycle 10 -> PKT_READY=0; data is not captured. The transfer occurs at the last GAP cycle.
- Reset at SHIFT counter 40 -> CLK_EN and SER_DATA drop to 0 asynchronously; no PKT_DONE. The next packet after release is serialized fully and correctly.

Source files
------------

// File: rtl/sb_tx_pkt_serializer.sv
// Sideband transmit serializer: accepts one packet over valid/ready, shifts it out LSB first
// with a one-cycle-leading clock-gate enable, then holds the lane quiet for the idle gap.
module sb_tx_pkt_serializer #(
    parameter int unsigned PKT_W = 64,
    parameter int unsigned GAP_W = 32,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PKT_W-1:0] pkt_data_i,
    input  logic             pkt_valid_i,
    output logic             pkt_ready_o,
    output logic             clk_en_o,
    output logic             ser_data_o,
    output logic             busy_o,
    output logic             pkt_done_o
);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PKT_END  = CNT_W'(PKT_W);
    localparam logic [CNT_W-1:0] CNT_CLK_LAST = CNT_W'(PKT_W - 1);
    localparam logic [CNT_W-1:0] CNT_GAP_END  = CNT_W'(GAP_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PKT_W-1:0]   shreg_q, shreg_d;
    logic               clk_en_q, clk_en_d;
    logic               ser_data_q, ser_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               xfer;

    // Ready in IDLE and in the last gap cycle so packets can run back-to-back.
    assign pkt_ready_o = (state_q == ST_IDLE) ||
                         ((state_q == ST_GAP) && (cnt_q == CNT_GAP_END));
    assign xfer        = pkt_valid_i && pkt_ready_o;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        clk_en_d   = 1'b0;
        ser_data_d = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = '0;
                    shreg_d  = pkt_data_i;
                    clk_en_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_PKT_END) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    // Enable leads data by one cycle, so it drops while the last bit goes out.
                    cnt_d      = cnt_q + CNT_ONE;
                    ser_data_d = shreg_q[0];
                    shreg_d    = {1'b0, shreg_q[PKT_W-1:1]};
                    clk_en_d   = (cnt_q != CNT_CLK_LAST);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_GAP_END) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (xfer) begin
                        state_d  = ST_SHIFT;
                        shreg_d  = pkt_data_i;
                        clk_en_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            clk_en_q   <= 1'b0;
            ser_data_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            clk_en_q   <= clk_en_d;
            ser_data_q <= ser_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign clk_en_o   = clk_en_q;
    assign ser_data_o = ser_data_q;
    assign busy_o     = busy_q;
    assign pkt_done_o = done_q;

endmodule

// File: tb/tb_sb_tx_pkt_serializer.sv
// Scoreboard bench: a latch-based clock-gating model feeds a falling-edge receiver; each
// received packet is checked against the queue of accepted packets and its gap/done timing.
module tb_sb_tx_pkt_serializer;

    localparam int unsigned PKT_W = 64;
    localparam int unsigned GAP_W = 32;

    typedef struct {
        logic [PKT_W-1:0] d;
        int unsigned      a;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PKT_W-1:0] pkt_data = '0;
    logic             pkt_valid = 1'b0;
    logic             pkt_ready, clk_en, ser_data, busy, pkt_done;

    logic             en_lat;
    logic             gated_clk;

    exp_t             exp_q[$];
    int unsigned      cyc = 0;
    int               n_cmp = 0;
    int               n_fail = 0;

    logic [PKT_W-1:0] rx_word = '0;
    int               rx_n = 0;
    int               pulse_cnt = 0;
    bit               pkt_complete = 0;
    bit               in_gap = 0;
    int               gap_s = 0;

    sb_tx_pkt_serializer #(.PKT_W(PKT_W), .GAP_W(GAP_W), .CNT_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_data_i (pkt_data),
        .pkt_valid_i(pkt_valid),
        .pkt_ready_o(pkt_ready),
        .clk_en_o   (clk_en),
        .ser_data_o (ser_data),
        .busy_o     (busy),
        .pkt_done_o (pkt_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Clock-gating cell: enable latched while clk is low.
    always_latch if (!clk) en_lat = clk_en;
    assign gated_clk = clk & en_lat;

    task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge gated_clk) begin
        if (!rst_n) begin
            n_cmp++; n_fail++;
            $display("FAIL runt_pulse: gated clock edge during reset (t=%0t)", $time);
        end else begin
            pulse_cnt++;
        end
    end

    // Receiver samples the lane on the gated-clock falling edge.
    always @(negedge gated_clk) begin
        if (rst_n && rx_n < PKT_W) begin
            rx_word[rx_n] = ser_data;
            rx_n++;
            if (rx_n == PKT_W) pkt_complete = 1;
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        rx_n = 0;
        pulse_cnt = 0;
        pkt_complete = 0;
        in_gap = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (pkt_complete) begin
                pkt_complete = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_pkt: got %0h, none expected", rx_word);
                end else begin
                    e = exp_q.pop_front();
                    chk("pkt_data", rx_word, e.d);
                    chk("pkt_latency", 64'(cyc), 64'(e.a + 65));
                end
                chk("gated_pulses", 64'(pulse_cnt), 64'(PKT_W));
                pulse_cnt = 0;
                rx_n = 0;
                in_gap = 1;
                gap_s = 0;
            end else if (in_gap) begin
                gap_s++;
                if (gap_s <= int'(GAP_W)) begin
                    chk("gap_quiet", {60'd0, busy, ser_data, clk_en, pkt_done}, 64'h8);
                end else begin
                    chk("pkt_done", 64'(pkt_done), 64'd1);
                    in_gap = 0;
                end
            end else begin
                chk("no_done", 64'(pkt_done), 64'd0);
                if (exp_q.size() == 0 && rx_n == 0 && pulse_cnt == 0)
                    chk("idle_outs", {61'd0, busy, clk_en, ser_data}, 64'd0);
            end
        end
    end

    // Drive a packet from a falling edge; returns the cycle index of the accepting edge.
    task automatic send(input logic [PKT_W-1:0] d, output int unsigned acc);
        int n;
        n = 0;
        pkt_data  = d;
        pkt_valid = 1'b1;
        while (!pkt_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: ready never seen, expected within 400 cycles");
            acc = 0;
        end else begin
            @(posedge clk);
            acc = cyc;
            exp_q.push_back('{d: d, a: cyc});
        end
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_gap || rx_n != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d packets pending, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned a1, a2;
        logic [PKT_W-1:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", {60'd0, clk_en, ser_data, busy, pkt_done}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(pkt_ready), 64'd1);
        @(negedge clk);

        // Single packet
        send(64'hA5A5_0000_FFFF_1234, a1);
        wait_idle();

        // Back-to-back with valid held
        send(64'h1, a1);
        send(64'h8000_0000_0000_0000, a2);
        chk("b2b_accept", 64'(a2), 64'(a1 + 97));
        wait_idle();

        // Stall: valid during shift cycle 10 is not accepted until the last gap cycle
        send(64'hDEAD_BEEF_0123_4567, a1);
        repeat (10) @(negedge clk);
        pkt_data  = 64'h0F0F_F0F0_3C3C_C3C3;
        pkt_valid = 1'b1;
        #1;
        chk("stall_ready", 64'(pkt_ready), 64'd0);
        send(64'h0F0F_F0F0_3C3C_C3C3, a2);
        chk("stall_accept", 64'(a2), 64'(a1 + 97));
        wait_idle();

        // Reset at shift counter 40
        send(64'hFFFF_FFFF_FFFF_FFFF, a1);
        repeat (40) @(negedge clk);
        chk("pre_rst_clk_en", 64'(clk_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {60'd0, clk_en, ser_data, busy, pkt_done}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_mid_rst", 64'(pkt_ready), 64'd1);
        @(negedge clk);
        send(64'h1357_9BDF_2468_ACE0, a1);
        wait_idle();

        // Random packets with random idle spacing (zero spacing runs back-to-back)
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 120)) @(negedge clk);
            send(d, a1);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
